hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 35 +++
 rtl/hazard_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard-control bundle: ID/EX hazard inputs, memory/branch status
// and the stall/flush controls that hazard_ctrl drives back into the pipeline.
// The master side belongs to the pipeline; the slave side belongs to hazard_ctrl.
interface hazard_ctrl_if;
  logic        Id_Ex_MemRead;
  logic [2:0]  Id_Ex_LdRd;
  logic [2:0]  If_Id_RegRn1;
  logic [2:0]  If_Id_RegRn2;
  logic [2:0]  If_Id_RegRd1;
  logic [2:0]  If_Id_RegRd2;
  logic        Branch_Taken;
  logic        Mem_Busy;
  logic        PC_Write;
  logic        If_Id_Write;
  logic        Id_Ex_Bubble;
  logic        If_Id_Flush;
  logic        Pipe_Hold;
  logic        Mem_Timeout;
  logic [1:0]  Hz_State;
  logic [15:0] Stall_Cnt;

  modport master (
    output Id_Ex_MemRead, Id_Ex_LdRd, If_Id_RegRn1, If_Id_RegRn2,
           If_Id_RegRd1, If_Id_RegRd2, Branch_Taken, Mem_Busy,
    input  PC_Write, If_Id_Write, Id_Ex_Bubble, If_Id_Flush, Pipe_Hold,
           Mem_Timeout, Hz_State, Stall_Cnt
  );

  modport slave (
    input  Id_Ex_MemRead, Id_Ex_LdRd, If_Id_RegRn1, If_Id_RegRn2,
           If_Id_RegRd1, If_Id_RegRd2, Branch_Taken, Mem_Busy,
    output PC_Write, If_Id_Write, Id_Ex_Bubble, If_Id_Flush, Pipe_Hold,
           Mem_Timeout, Hz_State, Stall_Cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard FSM (RUN / LDSTALL / MEMWAIT / FLUSH).
// Detects load-use hazards, waits out a busy data memory with a timeout,
// and flushes IF/ID on a taken branch. Control outputs are combinational
// from the state register and the current inputs.
// Optional build macro HZ_PERF_CNT_EN adds a saturating stall-cycle counter
// on Stall_Cnt; without it Stall_Cnt is tied to zero.
module hazard_ctrl #(
  parameter int LD_STALL = 1,   // total stall cycles per load-use hazard, 1..3
  parameter int MEM_TMO  = 15   // MEMWAIT cycle limit, 1..15
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam logic [1:0] S_RUN     = 2'b00;
  localparam logic [1:0] S_LDSTALL = 2'b01;
  localparam logic [1:0] S_MEMWAIT = 2'b10;
  localparam logic [1:0] S_FLUSH   = 2'b11;

  // RUN spends one stall cycle itself, so LDSTALL covers the remainder.
  localparam logic [1:0] LD_INIT = 2'(LD_STALL - 1);
  localparam logic [3:0] TMO_LIM = 4'(MEM_TMO);

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic [1:0] ld_cnt_r;
  logic [1:0] ld_cnt_nxt_s;
  logic [3:0] tmo_cnt_r;
  logic [3:0] tmo_cnt_nxt_s;
  logic       tmo_flag_r;
  logic       tmo_set_s;
  logic       lu_s;

  logic       pc_write_s;
  logic       if_id_write_s;
  logic       bubble_s;
  logic       flush_s;
  logic       hold_s;

  // Load-use hazard: EX load targets a nonzero register that ID reads.
  always_comb begin
    lu_s = 1'b0;
    if (hz.Id_Ex_MemRead && (hz.Id_Ex_LdRd != 3'd0)) begin
      lu_s = (hz.Id_Ex_LdRd == hz.If_Id_RegRn1) ||
             (hz.Id_Ex_LdRd == hz.If_Id_RegRn2) ||
             (hz.Id_Ex_LdRd == hz.If_Id_RegRd1) ||
             (hz.Id_Ex_LdRd == hz.If_Id_RegRd2);
    end else begin
      lu_s = 1'b0;
    end
  end

  // Next-state, counter updates and pipeline control outputs.
  always_comb begin
    pc_write_s    = 1'b1;
    if_id_write_s = 1'b1;
    bubble_s      = 1'b0;
    flush_s       = 1'b0;
    hold_s        = 1'b0;
    state_nxt_s   = state_r;
    ld_cnt_nxt_s  = ld_cnt_r;
    tmo_cnt_nxt_s = tmo_cnt_r;
    tmo_set_s     = 1'b0;
    if (rst) begin
      // Reset forces default controls and aborts any stall in progress.
      state_nxt_s   = S_RUN;
      ld_cnt_nxt_s  = 2'd0;
      tmo_cnt_nxt_s = 4'd0;
    end else begin
      case (state_r)
        S_RUN: begin
          if (hz.Branch_Taken) begin
            flush_s     = 1'b1;
            bubble_s    = 1'b1;
            state_nxt_s = S_FLUSH;
          end else if (hz.Mem_Busy) begin
            pc_write_s    = 1'b0;
            if_id_write_s = 1'b0;
            hold_s        = 1'b1;
            tmo_cnt_nxt_s = 4'd1;
            state_nxt_s   = S_MEMWAIT;
          end else if (lu_s) begin
            pc_write_s    = 1'b0;
            if_id_write_s = 1'b0;
            bubble_s      = 1'b1;
            if (LD_INIT != 2'd0) begin
              ld_cnt_nxt_s = LD_INIT;
              state_nxt_s  = S_LDSTALL;
            end else begin
              state_nxt_s  = S_RUN;
            end
          end else begin
            state_nxt_s = S_RUN;
          end
        end
        S_LDSTALL: begin
          // Branch and memory status are deliberately ignored here.
          pc_write_s    = 1'b0;
          if_id_write_s = 1'b0;
          bubble_s      = 1'b1;
          ld_cnt_nxt_s  = ld_cnt_r - 2'd1;
          if (ld_cnt_r <= 2'd1) begin
            ld_cnt_nxt_s = 2'd0;
            state_nxt_s  = S_RUN;
          end else begin
            state_nxt_s  = S_LDSTALL;
          end
        end
        S_MEMWAIT: begin
          // A pending branch is re-evaluated once back in RUN.
          pc_write_s    = 1'b0;
          if_id_write_s = 1'b0;
          hold_s        = 1'b1;
          if (!hz.Mem_Busy) begin
            tmo_cnt_nxt_s = 4'd0;
            state_nxt_s   = S_RUN;
          end else if (tmo_cnt_r == TMO_LIM) begin
            tmo_set_s     = 1'b1;
            tmo_cnt_nxt_s = 4'd0;
            state_nxt_s   = S_RUN;
          end else begin
            tmo_cnt_nxt_s = tmo_cnt_r + 4'd1;
            state_nxt_s   = S_MEMWAIT;
          end
        end
        S_FLUSH: begin
          flush_s     = 1'b1;
          bubble_s    = 1'b1;
          state_nxt_s = S_RUN;
        end
        default: begin
          state_nxt_s = S_RUN;
        end
      endcase
    end
  end

  // State, counters and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_RUN;
      ld_cnt_r   <= 2'd0;
      tmo_cnt_r  <= 4'd0;
      tmo_flag_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      ld_cnt_r   <= ld_cnt_nxt_s;
      tmo_cnt_r  <= tmo_cnt_nxt_s;
      tmo_flag_r <= tmo_flag_r | tmo_set_s;
    end
  end

`ifdef HZ_PERF_CNT_EN
  logic [15:0] perf_cnt_r;

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt_r <= 16'h0000;
    end else if (!pc_write_s && (perf_cnt_r != 16'hFFFF)) begin
      perf_cnt_r <= perf_cnt_r + 16'h0001;
    end else begin
      perf_cnt_r <= perf_cnt_r;
    end
  end

  assign hz.Stall_Cnt = perf_cnt_r;
`else
  assign hz.Stall_Cnt = 16'h0000;
`endif

  assign hz.PC_Write     = pc_write_s;
  assign hz.If_Id_Write  = if_id_write_s;
  assign hz.Id_Ex_Bubble = bubble_s;
  assign hz.If_Id_Flush  = flush_s;
  assign hz.Pipe_Hold    = hold_s;
  assign hz.Mem_Timeout  = tmo_flag_r;
  assign hz.Hz_State     = state_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a cycle-level behavioural model
// (remaining stall cycles, memory-wait count, pending flush) predicts every
// output each cycle, and directed scenarios pin it with literal values.
module tb_hazard_ctrl;
  localparam int LDS = 2;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;

  hazard_ctrl_if hz();

  hazard_ctrl #(.LD_STALL(LDS), .MEM_TMO(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic       pc;
    logic       ifw;
    logic       bub;
    logic       fl;
    logic       hold;
    logic [1:0] st;
  } exp_t;

  int m_ld_left = 0;   // LDSTALL cycles still owed
  bit m_mw      = 1'b0;
  int m_mw_n    = 0;   // MEMWAIT cycle number
  bit m_fl      = 1'b0;
  bit m_tmo     = 1'b0;
  int m_perf    = 0;

  function automatic bit lu_now();
    if (!hz.Id_Ex_MemRead || hz.Id_Ex_LdRd == 3'd0) return 1'b0;
    return (hz.Id_Ex_LdRd == hz.If_Id_RegRn1) || (hz.Id_Ex_LdRd == hz.If_Id_RegRn2) ||
           (hz.Id_Ex_LdRd == hz.If_Id_RegRd1) || (hz.Id_Ex_LdRd == hz.If_Id_RegRd2);
  endfunction

  function automatic exp_t predict();
    exp_t e;
    e = '{pc: 1'b1, ifw: 1'b1, bub: 1'b0, fl: 1'b0, hold: 1'b0, st: 2'b00};
    if (m_ld_left > 0) e.st = 2'b01;
    else if (m_mw)     e.st = 2'b10;
    else if (m_fl)     e.st = 2'b11;
    if (rst) return e;
    if (m_fl) begin
      e.fl = 1'b1; e.bub = 1'b1;
    end else if (m_ld_left > 0) begin
      e.pc = 1'b0; e.ifw = 1'b0; e.bub = 1'b1;
    end else if (m_mw) begin
      e.pc = 1'b0; e.ifw = 1'b0; e.hold = 1'b1;
    end else if (hz.Branch_Taken) begin
      e.fl = 1'b1; e.bub = 1'b1;
    end else if (hz.Mem_Busy) begin
      e.pc = 1'b0; e.ifw = 1'b0; e.hold = 1'b1;
    end else if (lu_now()) begin
      e.pc = 1'b0; e.ifw = 1'b0; e.bub = 1'b1;
    end
    return e;
  endfunction

  // Model advances on each rising edge from the inputs present at the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      e = predict();
      if (rst) begin
        m_ld_left = 0; m_mw = 1'b0; m_mw_n = 0; m_fl = 1'b0; m_tmo = 1'b0; m_perf = 0;
      end else begin
        if (!e.pc && m_perf < 65535) m_perf = m_perf + 1;
        if (m_fl) m_fl = 1'b0;
        else if (m_ld_left > 0) m_ld_left = m_ld_left - 1;
        else if (m_mw) begin
          if (!hz.Mem_Busy) m_mw = 1'b0;
          else if (m_mw_n == TMO) begin m_tmo = 1'b1; m_mw = 1'b0; end
          else m_mw_n = m_mw_n + 1;
        end
        else if (hz.Branch_Taken) m_fl = 1'b1;
        else if (hz.Mem_Busy) begin m_mw = 1'b1; m_mw_n = 1; end
        else if (lu_now()) m_ld_left = LDS - 1;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, on the falling edge.
  initial begin
    exp_t e;
    logic [15:0] exp_cnt;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e = predict();
`ifdef HZ_PERF_CNT_EN
        exp_cnt = 16'(m_perf);
`else
        exp_cnt = 16'h0000;
`endif
        check("cyc_PC_Write",     {15'd0, hz.PC_Write},     {15'd0, e.pc});
        check("cyc_If_Id_Write",  {15'd0, hz.If_Id_Write},  {15'd0, e.ifw});
        check("cyc_Id_Ex_Bubble", {15'd0, hz.Id_Ex_Bubble}, {15'd0, e.bub});
        check("cyc_If_Id_Flush",  {15'd0, hz.If_Id_Flush},  {15'd0, e.fl});
        check("cyc_Pipe_Hold",    {15'd0, hz.Pipe_Hold},    {15'd0, e.hold});
        check("cyc_Hz_State",     {14'd0, hz.Hz_State},     {14'd0, e.st});
        check("cyc_Mem_Timeout",  {15'd0, hz.Mem_Timeout},  {15'd0, m_tmo});
        check("cyc_Stall_Cnt",    hz.Stall_Cnt,             exp_cnt);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic mr, input logic [2:0] ld, input logic [2:0] rn1,
                         input logic [2:0] rn2, input logic [2:0] rd1, input logic [2:0] rd2);
    hz.Id_Ex_MemRead = mr;
    hz.Id_Ex_LdRd    = ld;
    hz.If_Id_RegRn1  = rn1;
    hz.If_Id_RegRn2  = rn2;
    hz.If_Id_RegRd1  = rd1;
    hz.If_Id_RegRd2  = rd2;
  endtask

  task automatic idle();
    set_ops(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
    hz.Branch_Taken = 1'b0;
    hz.Mem_Busy     = 1'b0;
  endtask

  initial begin
    exp_t em;
    int stalls;
    logic [2:0] f_reg;
    logic [15:0] perf_exp;
    idle();
    rst = 1'b1;
    hz.Branch_Taken = 1'b1;
    hz.Mem_Busy     = 1'b1;
    set_ops(1'b1, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0);

    // Reset held with every request active: controls stay at defaults.
    step();
    chk_en = 1'b1;
    #2;
    check("rst_PC_Write",  {15'd0, hz.PC_Write},     16'd1);
    check("rst_Pipe_Hold", {15'd0, hz.Pipe_Hold},    16'd0);
    check("rst_Flush",     {15'd0, hz.If_Id_Flush},  16'd0);
    check("rst_Bubble",    {15'd0, hz.Id_Ex_Bubble}, 16'd0);
    step();
    rst = 1'b0;
    idle();
    #2;
    check("post_rst_state", {14'd0, hz.Hz_State},    16'd0);
    check("post_rst_tmo",   {15'd0, hz.Mem_Timeout}, 16'd0);
    check("post_rst_cnt",   hz.Stall_Cnt,            16'd0);
    step();

    // Register 0 never hazards.
    set_ops(1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
    #2; check("r0_PC_Write", {15'd0, hz.PC_Write}, 16'd1);
    step();
    #2; check("r0_PC_Write2", {15'd0, hz.PC_Write}, 16'd1);
    step();

    // Load-use on Rn2 with LD_STALL=2: two stall cycles, 00->01->00.
    set_ops(1'b1, 3'd3, 3'd0, 3'd3, 3'd0, 3'd0);
    #2;
    check("lu_c1_pc",  {15'd0, hz.PC_Write},     16'd0);
    check("lu_c1_bub", {15'd0, hz.Id_Ex_Bubble}, 16'd1);
    check("lu_c1_st",  {14'd0, hz.Hz_State},     16'd0);
    step();
    idle();
    #2;
    em = predict();
    check("model_lu_st", {14'd0, em.st},         16'd1);
    check("lu_c2_pc",    {15'd0, hz.PC_Write},   16'd0);
    check("lu_c2_bub",   {15'd0, hz.Id_Ex_Bubble}, 16'd1);
    check("lu_c2_st",    {14'd0, hz.Hz_State},   16'd1);
    step();
    #2;
    check("lu_c3_pc", {15'd0, hz.PC_Write}, 16'd1);
    check("lu_c3_st", {14'd0, hz.Hz_State}, 16'd0);
    step();

    // Each operand field in turn produces exactly LD_STALL stall cycles.
    for (int f = 0; f < 4; f++) begin
      f_reg = 3'd5;
      set_ops(1'b1, f_reg, (f == 0) ? f_reg : 3'd1, (f == 1) ? f_reg : 3'd1,
              (f == 2) ? f_reg : 3'd1, (f == 3) ? f_reg : 3'd1);
      stalls = 0;
      for (int k = 0; k < 4; k++) begin
        #2;
        if (!hz.PC_Write) stalls = stalls + 1;
        step();
        idle();
      end
      check("lu_field_stalls", 16'(stalls), 16'd2);
    end

    // Matching register but no load in EX: no stall.
    set_ops(1'b0, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4);
    #2; check("noload_pc", {15'd0, hz.PC_Write}, 16'd1);
    step();
    idle();

    // Priority: branch beats memory busy and load-use.
    hz.Branch_Taken = 1'b1;
    hz.Mem_Busy     = 1'b1;
    set_ops(1'b1, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0);
    #2;
    check("pri_c1_flush", {15'd0, hz.If_Id_Flush}, 16'd1);
    check("pri_c1_hold",  {15'd0, hz.Pipe_Hold},   16'd0);
    check("pri_c1_st",    {14'd0, hz.Hz_State},    16'd0);
    step();
    #2;
    check("pri_c2_flush", {15'd0, hz.If_Id_Flush}, 16'd1);
    check("pri_c2_st",    {14'd0, hz.Hz_State},    16'd3);
    step();
    hz.Branch_Taken = 1'b0;
    #2;
    check("pri_c3_st",    {14'd0, hz.Hz_State},  16'd0);
    check("pri_c3_hold",  {15'd0, hz.Pipe_Hold}, 16'd1);
    step();
    hz.Mem_Busy = 1'b0;
    #2;
    check("pri_c4_st",    {14'd0, hz.Hz_State},  16'd2);
    check("pri_c4_hold",  {15'd0, hz.Pipe_Hold}, 16'd1);
    step();
    idle();
    #2; check("pri_c5_pc", {15'd0, hz.PC_Write}, 16'd1);
    step();

    // Memory timeout: 15 MEMWAIT cycles, then sticky flag and re-entry.
    hz.Mem_Busy = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      #2;
      check("tmo_st",   {14'd0, hz.Hz_State},
            ((i == 1) || (i == 17)) ? 16'd0 : 16'd2);
      check("tmo_flag", {15'd0, hz.Mem_Timeout}, (i >= 17) ? 16'd1 : 16'd0);
      check("tmo_hold", {15'd0, hz.Pipe_Hold},   16'd1);
      step();
    end
    hz.Mem_Busy = 1'b0;
    #2; check("tmo_exit_st", {14'd0, hz.Hz_State}, 16'd2);
    step();
    #2;
    check("tmo_idle_st",   {14'd0, hz.Hz_State},    16'd0);
    check("tmo_sticky",    {15'd0, hz.Mem_Timeout}, 16'd1);
    check("tmo_idle_pc",   {15'd0, hz.PC_Write},    16'd1);
    step();

    // Reset during MEMWAIT cycle 5.
    hz.Mem_Busy = 1'b1;
    step();
    repeat (4) step();
    #2; check("mw5_st", {14'd0, hz.Hz_State}, 16'd2);
    rst = 1'b1;
    #1;
    check("mrst_pc",   {15'd0, hz.PC_Write},  16'd1);
    check("mrst_hold", {15'd0, hz.Pipe_Hold}, 16'd0);
    step();
    rst = 1'b0;
    hz.Mem_Busy = 1'b0;
    #2;
    check("mrst_st",    {14'd0, hz.Hz_State},    16'd0);
    check("mrst_tmo",   {15'd0, hz.Mem_Timeout}, 16'd0);
    check("mrst_cnt",   hz.Stall_Cnt,            16'd0);
    check("mrst_pc2",   {15'd0, hz.PC_Write},    16'd1);
    check("mrst_hold2", {15'd0, hz.Pipe_Hold},   16'd0);
    step();

    // Performance count: 3 load-use hazards (2 cycles each) + 1 entry + 4 MEMWAIT.
    for (int n = 0; n < 3; n++) begin
      set_ops(1'b1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0);
      step();
      idle();
      step();
      step();
    end
    hz.Mem_Busy = 1'b1;
    repeat (4) step();
    hz.Mem_Busy = 1'b0;
    step();
    #2;
`ifdef HZ_PERF_CNT_EN
    perf_exp = 16'd11;
`else
    perf_exp = 16'd0;
`endif
    check("perf_cnt", hz.Stall_Cnt, perf_exp);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
